// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Initiator-side controller for a single-port register file (one address, wen=1 writes,
//   wen=0 reads with a registered dout one cycle later). Fetches two source operands in
//   sequence for decode and performs writebacks. x0 reads as zero and writes to x0 are dropped.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   req_valid_i/ready_o    operand fetch request handshake, indices req_rs1_i / req_rs2_i
//   op_valid_o/ready_i     operand pair handshake, data op_rs1_data_o / op_rs2_data_o
//   wb_valid_i/ready_o     writeback handshake, destination wb_rd_i, data wb_data_i
//   rf_addr_o, rf_din_o,
//   rf_wen_o, rf_dout_i    register file interface
module regfile_access_ctrl #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned ADDRBITS = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDRBITS-1:0] req_rs1_i,
  input  logic [ADDRBITS-1:0] req_rs2_i,
  output logic                op_valid_o,
  input  logic                op_ready_i,
  output logic [WORDSIZE-1:0] op_rs1_data_o,
  output logic [WORDSIZE-1:0] op_rs2_data_o,
  input  logic                wb_valid_i,
  output logic                wb_ready_o,
  input  logic [ADDRBITS-1:0] wb_rd_i,
  input  logic [WORDSIZE-1:0] wb_data_i,
  output logic [ADDRBITS-1:0] rf_addr_o,
  output logic [WORDSIZE-1:0] rf_din_o,
  output logic                rf_wen_o,
  input  logic [WORDSIZE-1:0] rf_dout_i
);

  typedef enum logic [1:0] {StIdle, StRd2, StCap2, StOut} state_e;

  state_e                state_q;
  logic [ADDRBITS-1:0]   rs1_q;
  logic [ADDRBITS-1:0]   rs2_q;
  logic                  op_valid_q;
  logic [WORDSIZE-1:0]   rs1_data_q;
  logic [WORDSIZE-1:0]   rs2_data_q;

  // rs1 is presented while in StIdle, so its data arrives in StRd2; rs2 is presented in StRd2
  // and its data arrives in StCap2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      rs1_q      <= '0;
      rs2_q      <= '0;
      op_valid_q <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Writeback wins the port; the request waits for a cycle without one.
          if (!wb_valid_i && req_valid_i) begin
            rs1_q   <= req_rs1_i;
            rs2_q   <= req_rs2_i;
            state_q <= StRd2;
          end
        end
        StRd2: begin
          rs1_data_q <= (rs1_q == '0) ? '0 : rf_dout_i;
          state_q    <= StCap2;
        end
        StCap2: begin
          rs2_data_q <= (rs2_q == '0) ? '0 : rf_dout_i;
          op_valid_q <= 1'b1;
          state_q    <= StOut;
        end
        StOut: begin
          if (op_ready_i) begin
            op_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          op_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    wb_ready_o  = 1'b0;
    rf_wen_o    = 1'b0;
    rf_addr_o   = rs2_q;
    if (state_q == StIdle) begin
      wb_ready_o = 1'b1;
      if (wb_valid_i) begin
        rf_addr_o = wb_rd_i;
        // x0 writes are acknowledged but never reach the array.
        rf_wen_o  = (wb_rd_i != '0);
      end else begin
        req_ready_o = 1'b1;
        rf_addr_o   = req_rs1_i;
      end
    end
  end

  assign rf_din_o      = wb_data_i;
  assign op_valid_o    = op_valid_q;
  assign op_rs1_data_o = rs1_data_q;
  assign op_rs2_data_o = rs2_data_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [31:0] op_rs1_data;
  logic [31:0] op_rs2_data;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_din;
  logic        rf_wen;
  logic [31:0] rf_dout = '0;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_access_ctrl #(.WORDSIZE(32), .ADDRBITS(5)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_rs1_i    (req_rs1),
    .req_rs2_i    (req_rs2),
    .op_valid_o   (op_valid),
    .op_ready_i   (op_ready),
    .op_rs1_data_o(op_rs1_data),
    .op_rs2_data_o(op_rs2_data),
    .wb_valid_i   (wb_valid),
    .wb_ready_o   (wb_ready),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data),
    .rf_addr_o    (rf_addr),
    .rf_din_o     (rf_din),
    .rf_wen_o     (rf_wen),
    .rf_dout_i    (rf_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    return 32'hC0DE_0000 | i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file environment; x0 deliberately holds garbage so the controller must mask it.
  logic [31:0] rf_mem [32];
  logic        rf_seeded = 1'b0;
  always @(posedge clk) begin
    if (!rf_seeded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= seed(i);
      rf_seeded <= 1'b1;
    end else if (rf_wen) begin
      rf_mem[rf_addr] <= rf_din;
    end else begin
      rf_dout <= rf_mem[rf_addr];
    end
  end

  // Transaction-level model: architectural registers plus one outstanding fetch.
  logic [31:0] arch [32];
  logic        m_seeded = 1'b0;
  logic        busy_m = 1'b0;
  int          cyc = 0;
  int          due = 0;
  logic [31:0] e1 = '0;
  logic [31:0] e2 = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_m <= 1'b0;
      if (!m_seeded) begin
        for (int i = 0; i < 32; i++) arch[i] <= seed(i);
        m_seeded <= 1'b1;
      end
    end else begin
      if (!busy_m) begin
        if (wb_valid) begin
          if (wb_rd != 0) arch[wb_rd] <= wb_data;
        end else if (req_valid) begin
          busy_m <= 1'b1;
          due    <= cyc + 3;
          e1     <= (req_rs1 == 0) ? 32'h0 : arch[req_rs1];
          e2     <= (req_rs2 == 0) ? 32'h0 : arch[req_rs2];
        end
      end else if (cyc >= due && op_ready) begin
        busy_m <= 1'b0;
      end
    end
    if (rstn) cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    logic exp_valid;
    exp_valid = busy_m && (cyc >= due);
    chk("op_valid", op_valid, exp_valid);
    chk("req_ready", req_ready, !busy_m && !wb_valid);
    chk("wb_ready", wb_ready, !busy_m);
    chk("rf_wen", rf_wen, !busy_m && wb_valid && (wb_rd != 0));
    chk("rf_din", rf_din, wb_data);
    if (exp_valid) begin
      chk("op_rs1_data", op_rs1_data, e1);
      chk("op_rs2_data", op_rs2_data, e2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    #1;
    chk("wr_wb_ready", wb_ready, 1'b1);
    chk("wr_rf_wen", rf_wen, (rd != 0));
    tick();
    wb_valid = 1'b0;
  endtask

  // Issues a fetch (port assumed free), checks latency, holds op_ready low for hold cycles.
  task automatic fetch(input logic [4:0] rs1, input logic [4:0] rs2, input int hold,
                       output logic [31:0] d1, output logic [31:0] d2);
    int n;
    req_valid = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    #1;
    chk("fetch_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (op_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_latency", n + 1, 3);
    d1 = op_rs1_data;
    d2 = op_rs2_data;
    repeat (hold) tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("fetch_released", op_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] d1, d2;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_rs1_data", op_rs1_data, 32'h0);
    chk("rst_rs2_data", op_rs2_data, 32'h0);
    chk("rst_wb_ready", wb_ready, 1'b1);
    rstn = 1'b1;
    tick();

    // 1: write x5, fetch x5/x0
    write_reg(5'd5, 32'hDEADBEEF);
    fetch(5'd5, 5'd0, 0, d1, d2);
    chk("t1_rs1", d1, 32'hDEADBEEF);
    chk("t1_rs2", d2, 32'h0);

    // 2: x0 write dropped, x0 reads zero despite array garbage
    write_reg(5'd0, 32'h00001234);
    fetch(5'd0, 5'd0, 0, d1, d2);
    chk("t2_rs1", d1, 32'h0);
    chk("t2_rs2", d2, 32'h0);

    // 3: simultaneous writeback and request; write first, then read-after-write
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd3;
    #1;
    chk("t3_req_ready_blocked", req_ready, 1'b0);
    chk("t3_wb_ready", wb_ready, 1'b1);
    chk("t3_rf_wen", rf_wen, 1'b1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("t3_req_ready_next", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (op_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t3_latency", n + 1, 3);
    chk("t3_rs1", op_rs1_data, 32'hA5A5A5A5);
    chk("t3_rs2", op_rs2_data, 32'hC0DE0003);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // 4: consumer stalls 5 cycles in OUT while a writeback waits
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd7;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h11112222;
    for (int i = 0; i < 5; i++) begin
      chk("t4_op_valid", op_valid, 1'b1);
      chk("t4_rs1_stable", op_rs1_data, 32'hDEADBEEF);
      chk("t4_rs2_stable", op_rs2_data, 32'hA5A5A5A5);
      chk("t4_req_ready", req_ready, 1'b0);
      chk("t4_wb_ready", wb_ready, 1'b0);
      chk("t4_rf_wen", rf_wen, 1'b0);
      tick();
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("t4_idle_op_valid", op_valid, 1'b0);
    chk("t4_idle_wb_ready", wb_ready, 1'b1);
    tick();
    wb_valid = 1'b0;
    fetch(5'd9, 5'd0, 0, d1, d2);
    chk("t4_stalled_write", d1, 32'h11112222);

    // 5: same register on both sources
    write_reg(5'd12, 32'h00000042);
    fetch(5'd12, 5'd12, 1, d1, d2);
    chk("t5_rs1", d1, 32'h00000042);
    chk("t5_rs2", d2, 32'h00000042);

    // 6: reset while in RD2
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd12;
    tick();
    req_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("t6_rst_op_valid", op_valid, 1'b0);
    chk("t6_rst_rf_wen", rf_wen, 1'b0);
    chk("t6_rst_req_ready", req_ready, 1'b1);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_pulse", op_valid, 1'b0);
      tick();
    end
    fetch(5'd12, 5'd5, 0, d1, d2);
    chk("t6_rs1", d1, 32'h00000042);
    chk("t6_rs2", d2, 32'hDEADBEEF);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
